// File: rtl/dino_game_ctrl.sv
// Top-level game sequencer for the dino runner.
// It turns space-key presses into start, jump and restart requests, and gates datapath motion.
// It latches dino/obstacle overlap seen during scan-out, and keeps the score, high score and
// obstacle speed.
module dino_game_ctrl #(
  parameter logic [7:0]  SPACE_KEY = 8'h2C,
  parameter int unsigned SCORE_DIV = 6,
  parameter int unsigned SPEED_PTS = 50,
  parameter logic [9:0]  STEP_INIT = 10'd2,
  parameter logic [9:0]  STEP_MAX  = 10'd8,
  parameter int unsigned OVER_HOLD = 30
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [7:0]  keycode,
  input  logic        is_ball,
  input  logic        is_tree,
  output logic        run_en,
  output logic        restart,
  output logic        jump_req,
  output logic [9:0]  obs_step,
  output logic [1:0]  game_state,
  output logic [13:0] score,
  output logic [13:0] hi_score
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StOver = 2'd2
  } state_e;

  localparam logic [15:0] FrameLast = 16'(SCORE_DIV - 1);
  localparam logic [15:0] PtsLast   = 16'(SPEED_PTS - 1);
  localparam logic [15:0] HoldMax   = 16'(OVER_HOLD);
  localparam logic [13:0] ScoreMax  = 14'd9999;

  state_e      state_q, state_d;
  logic        run_en_q, run_en_d;
  logic        restart_q, restart_d;
  logic        jump_req_q, jump_req_d;
  logic [9:0]  obs_step_q, obs_step_d;
  logic [13:0] score_q, score_d;
  logic [13:0] hi_score_q, hi_score_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] pt_cnt_q, pt_cnt_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic        frame_dly_q, frame_dly_d;
  logic        frame_tick_q, frame_tick_d;
  logic        key_prev_q, key_prev_d;
  logic        coll_q, coll_d;

  logic key_now, press, hit, coll_seen, start;

  // Next-state logic: edge detectors, collision latch and the game sequencer.
  always_comb begin
    key_now   = (keycode == SPACE_KEY);
    press     = key_now & ~key_prev_q;
    hit       = is_ball & is_tree;
    // An overlap on the tick cycle itself still belongs to the frame being closed.
    coll_seen = coll_q | hit;
    start     = 1'b0;

    frame_dly_d  = frame_clk;
    frame_tick_d = frame_clk & ~frame_dly_q;
    key_prev_d   = key_now;
    coll_d       = frame_tick_q ? 1'b0 : coll_seen;

    state_d     = state_q;
    restart_d   = 1'b0;
    jump_req_d  = 1'b0;
    obs_step_d  = obs_step_q;
    score_d     = score_q;
    hi_score_d  = hi_score_q;
    frame_cnt_d = frame_cnt_q;
    pt_cnt_d    = pt_cnt_q;
    hold_cnt_d  = hold_cnt_q;

    case (state_q)
      StIdle: begin
        // A coincident frame tick is ignored when the game starts.
        if (press) start = 1'b1;
      end
      StRun: begin
        if (frame_tick_q && coll_seen) begin
          // Game over wins over a coincident press and freezes score/speed for this tick.
          state_d    = StOver;
          hold_cnt_d = '0;
          if (score_q > hi_score_q) hi_score_d = score_q;
        end else begin
          if (press) jump_req_d = 1'b1;
          if (frame_tick_q) begin
            if (frame_cnt_q == FrameLast) begin
              frame_cnt_d = '0;
              if (score_q != ScoreMax) score_d = score_q + 14'd1;
              if (pt_cnt_q == PtsLast) begin
                pt_cnt_d   = '0;
                obs_step_d = (obs_step_q >= STEP_MAX) ? STEP_MAX : obs_step_q + 10'd1;
              end else begin
                pt_cnt_d = pt_cnt_q + 16'd1;
              end
            end else begin
              frame_cnt_d = frame_cnt_q + 16'd1;
            end
          end
        end
      end
      StOver: begin
        if (press && (hold_cnt_q == HoldMax)) begin
          start = 1'b1;
        end else if (frame_tick_q && (hold_cnt_q != HoldMax)) begin
          hold_cnt_d = hold_cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      state_d     = StRun;
      restart_d   = 1'b1;
      score_d     = '0;
      obs_step_d  = STEP_INIT;
      frame_cnt_d = '0;
      pt_cnt_d    = '0;
    end

    run_en_d = (state_d == StRun);
  end

  // All state and registered outputs, synchronous active-high reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= StIdle;
      run_en_q     <= 1'b0;
      restart_q    <= 1'b0;
      jump_req_q   <= 1'b0;
      obs_step_q   <= STEP_INIT;
      score_q      <= '0;
      hi_score_q   <= '0;
      frame_cnt_q  <= '0;
      pt_cnt_q     <= '0;
      hold_cnt_q   <= '0;
      frame_dly_q  <= 1'b0;
      frame_tick_q <= 1'b0;
      key_prev_q   <= 1'b0;
      coll_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_en_q     <= run_en_d;
      restart_q    <= restart_d;
      jump_req_q   <= jump_req_d;
      obs_step_q   <= obs_step_d;
      score_q      <= score_d;
      hi_score_q   <= hi_score_d;
      frame_cnt_q  <= frame_cnt_d;
      pt_cnt_q     <= pt_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      frame_dly_q  <= frame_dly_d;
      frame_tick_q <= frame_tick_d;
      key_prev_q   <= key_prev_d;
      coll_q       <= coll_d;
    end
  end

  assign run_en     = run_en_q;
  assign restart    = restart_q;
  assign jump_req   = jump_req_q;
  assign obs_step   = obs_step_q;
  assign game_state = state_q;
  assign score      = score_q;
  assign hi_score   = hi_score_q;

endmodule

// File: tb/tb_dino_game_ctrl.sv
// Scoreboard bench for dino_game_ctrl.
// A game-level reference model predicts every change of the outputs and every pulse.
// A monitor pops the predictions and compares them whenever the DUT's outputs change or pulse.
module tb_dino_game_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic [7:0]  keycode = 8'h00;
  logic        is_ball = 1'b0;
  logic        is_tree = 1'b0;
  logic        run_en, restart, jump_req;
  logic [9:0]  obs_step;
  logic [1:0]  game_state;
  logic [13:0] score, hi_score;

  dino_game_ctrl dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .keycode    (keycode),
    .is_ball    (is_ball),
    .is_tree    (is_tree),
    .run_en     (run_en),
    .restart    (restart),
    .jump_req   (jump_req),
    .obs_step   (obs_step),
    .game_state (game_state),
    .score      (score),
    .hi_score   (hi_score)
  );

  typedef struct packed {
    logic [1:0]  st;
    logic        run;
    logic        rst;
    logic        jmp;
    logic [9:0]  step;
    logic [13:0] sc;
    logic [13:0] hi;
  } rec_t;

  localparam rec_t ResetRec = '{st: 2'd0, run: 1'b0, rst: 1'b0, jmp: 1'b0,
                                step: 10'd2, sc: 14'd0, hi: 14'd0};

  rec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  always #10 Clk = ~Clk;

  // Frame clock: 16 Clk period, Clk-synchronous.
  initial begin
    forever begin
      repeat (8) @(negedge Clk);
      frame_clk = ~frame_clk;
    end
  end

  // Reference model: a game is a count of frames survived; score and speed follow from it.
  int   m_state = 0;       // 0 idle, 1 run, 2 over
  int   m_run_ticks = 0;   // scoring frames in the current game
  int   m_over_ticks = 0;  // frames spent in OVER
  int   m_hi = 0;
  bit   m_kprev = 0, m_fprev = 0, m_tick = 0, m_hitseen = 0;
  rec_t m_prev = ResetRec;

  function automatic int m_score();
    int s;
    s = m_run_ticks / 6;
    return (s > 9999) ? 9999 : s;
  endfunction

  function automatic int m_step();
    int s;
    s = 2 + (m_run_ticks / 6) / 50;
    return (s > 8) ? 8 : s;
  endfunction

  always @(posedge Clk) begin
    bit   hit, kn, press, tick, coll, n_rst, n_jmp;
    rec_t r;
    hit   = is_ball && is_tree;
    kn    = (keycode == 8'h2C);
    press = kn && !m_kprev;
    tick  = m_tick;
    n_rst = 0;
    n_jmp = 0;
    if (Reset) begin
      m_state = 0; m_run_ticks = 0; m_over_ticks = 0; m_hi = 0;
      m_kprev = 0; m_fprev = 0; m_tick = 0; m_hitseen = 0;
    end else begin
      coll = m_hitseen || hit;
      case (m_state)
        0: if (press) begin m_state = 1; m_run_ticks = 0; n_rst = 1; end
        1: begin
          if (tick && coll) begin
            if (m_score() > m_hi) m_hi = m_score();
            m_state = 2;
            m_over_ticks = 0;
          end else begin
            if (press) n_jmp = 1;
            if (tick) m_run_ticks++;
          end
        end
        default: begin
          if (press && m_over_ticks >= 30) begin
            m_state = 1; m_run_ticks = 0; n_rst = 1;
          end else if (tick) begin
            m_over_ticks++;
          end
        end
      endcase
      m_hitseen = tick ? 1'b0 : coll;
      m_tick    = frame_clk && !m_fprev;
      m_fprev   = frame_clk;
      m_kprev   = kn;
    end
    r.st   = 2'(m_state);
    r.run  = (m_state == 1);
    r.rst  = n_rst;
    r.jmp  = n_jmp;
    r.step = 10'(m_step());
    r.sc   = 14'(m_score());
    r.hi   = 14'(m_hi);
    if (r !== m_prev || n_rst || n_jmp) exp_q.push_back(r);
    m_prev = r;
  end

  // Monitor: every change or pulse on the outputs consumes one prediction.
  rec_t last = ResetRec;
  always @(negedge Clk) begin
    rec_t got, exp;
    if (mon_en) begin
      got = '{st: game_state, run: run_en, rst: restart, jmp: jump_req,
              step: obs_step, sc: score, hi: hi_score};
      if (got !== last || restart || jump_req) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event t=%0t got st=%0d run=%0d rst=%0d jmp=%0d step=%0d sc=%0d hi=%0d",
                   $time, got.st, got.run, got.rst, got.jmp, got.step, got.sc, got.hi);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL event t=%0t got st=%0d run=%0d rst=%0d jmp=%0d step=%0d sc=%0d hi=%0d | exp st=%0d run=%0d rst=%0d jmp=%0d step=%0d sc=%0d hi=%0d",
                     $time, got.st, got.run, got.rst, got.jmp, got.step, got.sc, got.hi,
                     exp.st, exp.run, exp.rst, exp.jmp, exp.step, exp.sc, exp.hi);
          end
        end
        last = got;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic frames(input int n);
    cycles(n * 16);
  endtask

  task automatic press_space();
    keycode = 8'h2C;
    cycles(4);
    keycode = 8'h00;
    cycles(2);
  endtask

  task automatic collide();
    is_ball = 1'b1;
    is_tree = 1'b1;
    cycles(1);
    is_ball = 1'b0;
    is_tree = 1'b0;
  endtask

  initial begin
    rec_t got;
    int   r;
    cycles(3);
    got = '{st: game_state, run: run_en, rst: restart, jmp: jump_req,
            step: obs_step, sc: score, hi: hi_score};
    checks++;
    if (got !== ResetRec) begin
      errors++;
      $display("FAIL reset_state got st=%0d run=%0d rst=%0d jmp=%0d step=%0d sc=%0d hi=%0d",
               got.st, got.run, got.rst, got.jmp, got.step, got.sc, got.hi);
    end
    Reset  = 1'b0;
    mon_en = 1'b1;

    // Game 1: start, held key gives one jump, collide near score 7.
    press_space();
    frames(5);
    keycode = 8'h2C;
    cycles(500);
    keycode = 8'h00;
    frames(8);
    collide();
    frames(2);
    // OVER: early press ignored, later press restarts.
    frames(10);
    press_space();
    frames(25);
    press_space();

    // Game 2: short game, high score must not drop.
    frames(20);
    collide();
    frames(32);
    press_space();

    // Game 3: long run, speed saturates.
    frames(2100);
    collide();
    frames(32);
    press_space();

    // Game 4: reset mid-game.
    frames(245);
    Reset = 1'b1;
    cycles(3);
    Reset = 1'b0;
    cycles(2);

    // Random play.
    repeat (600) begin
      r = $urandom_range(0, 9);
      if (r < 5)      keycode = 8'h00;
      else if (r < 8) keycode = 8'h2C;
      else            keycode = 8'($urandom_range(1, 255));
      is_ball = 1'($urandom_range(0, 1));
      is_tree = ($urandom_range(0, 29) == 0);
      cycles(1);
      is_tree = 1'b0;
      cycles($urandom_range(0, 39));
    end
    keycode = 8'h00;
    is_ball = 1'b0;
    cycles(40);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_events got=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
